mem_line_responder: RTL and testbench
=====================================

# mem_line_responder

Main-memory responder for the data cache's line-transfer requests. It accepts one line request at a time from the cache control unit, either a dirty-line writeback or a refill read. It models a fixed access latency, then moves the line one word per cycle into or out of its word array. It signals completion with a single-cycle `done` pulse. It sits between the cache controller and the backing memory array, replacing the controller's own blind 4-cycle wait with an explicit handshake.

## Interface
- `WORD_W`, 32, data word width in bits
- `WORDS`, 4, words per cache line (≥1)
- `ADDR_W`, 8, line-address width; the array holds 2^ADDR_W lines
- `LATENCY`, 4, access-latency cycles before the first word moves (≥1)

- `clk`  in  1  clock, rising edge
- `rst_b`  in  1  reset; asynchronous, active-low
- `req`  in  1  request valid (level); sampled only in IDLE
- `req_we`  in  1  1 = writeback (store line), 0 = refill (load line)
- `req_addr`  in  ADDR_W  line address
- `wdata`  in  WORDS*WORD_W  line to store; word i at bits [i*WORD_W +: WORD_W]
- `rdata`  out  WORDS*WORD_W  line loaded, same packing as `wdata`
- `busy`  out  1  high from acceptance through the DONE cycle
- `done`  out  1  one-cycle completion pulse

## Operation
- Storage: WORDS·2^ADDR_W words, word index {line_addr, i}. The array is not reset. Contents persist across `rst_b`.
- States: IDLE, WAIT, XFER, DONE.
- IDLE: on an edge with `req`=1, latch `req_we`, `req_addr` and `wdata`, load the latency counter with LATENCY-1, and go to WAIT. If `req`=0, stay in IDLE.
- WAIT: decrement the counter each edge. When the counter is 0, clear the word index and go to XFER.
- XFER: each edge moves word i, then increments i.
  - Writeback: array[{addr,i}] ← latched word i.
  - Refill: `rdata` word i ← array[{addr,i}].
  - After word WORDS-1, go to DONE.
- DONE: `done`=1 for exactly this cycle, then go to IDLE on the next edge.
- `req` is ignored in WAIT, XFER and DONE. No queueing. The requester must hold `req` until `done` and drop it the cycle `done` is seen, otherwise the request is re-accepted.
- Input changes after acceptance have no effect. The latched copies are used throughout.
- `rdata` holds its value until overwritten word-by-word by a later refill. A writeback does not modify `rdata`.
- Reset (async, any state): state → IDLE; `busy`=0, `done`=0, `rdata`=0; counters cleared. Words already written by an aborted writeback remain written. Remaining words are not written.

## Timing
- Request accepted at edge t0.
- WAIT occupies edges t0+1 … t0+LATENCY.
- Word i transfers at edge t0+LATENCY+1+i.
- DONE is entered at edge t0+LATENCY+WORDS. `done` is high between edges t0+LATENCY+WORDS and t0+LATENCY+WORDS+1.
- Defaults: accept at edge 0, words at edges 5–8, `done` high after edge 8, IDLE after edge 9. The earliest next acceptance is edge 10.
- `busy` rises after t0 and falls after the edge that leaves DONE.
- Full refill `rdata` is valid whenever `done`=1 for a refill.
- Back-to-back service interval: LATENCY+WORDS+2 cycles.
- LATENCY=1: WAIT lasts one cycle, and word 0 moves at t0+2.

## Test plan
- Reset: assert `rst_b`=0 mid-cycle → `busy`, `done` and `rdata` go to 0 immediately, with no clock edge needed.
- Writeback then refill (defaults): writeback addr 0x12 with `wdata`=0x44444444_33333333_22222222_11111111, then refill addr 0x12 → `done` pulses after edges 8 and 18 respectively. After the second `done`, `rdata` equals the written line.
- Latency check with LATENCY=1, WORDS=1: refill accepted at edge 0 → word moves at edge 2, `done` high only after edge 2, `busy` high for exactly 3 cycles.
- Request while busy: hold `req`=1 with a new addr 0x34 during WAIT/XFER of a request to addr 0x12 → only 0x12 is serviced; 0x34 is accepted at edge 10 only because `req` is still high.
- Input hold-off: change `wdata` and `req_addr` at edge 2 of a writeback to 0x05 → line 0x05 holds the originally latched data; the other address is untouched.
- Reset mid-writeback: writeback accepted at edge 0, reset after edge 6 (words 0–1 written) → words 0–1 hold new data, words 2–3 keep old data, and the next request is accepted normally.

Source files
------------

// File: rtl/mem_line_responder.sv
// Main-memory responder for cache line writebacks and refills.
// One request at a time: fixed access latency, then one word per cycle, then a done pulse.
module mem_line_responder #(
    parameter int WORD_W  = 32,
    parameter int WORDS   = 4,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    req,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [WORDS*WORD_W-1:0] wdata,
    output logic [WORDS*WORD_W-1:0] rdata,
    output logic                    busy,
    output logic                    done
);
    localparam int LINE_W = WORDS * WORD_W;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              line_we;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] line_data;

    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1][0:WORDS-1];

    // Request copies are taken only at acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            line_we   <= req_we;
            line_addr <= req_addr;
            line_data <= wdata;
        end
    end

    // The array has no reset: words written before a reset abort stay written.
    always_ff @(posedge clk) begin
        if (state == S_XFER && line_we) begin
            mem[line_addr][idx] <= line_data[idx*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_XFER;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_XFER: begin
                    if (!line_we) begin
                        rdata[idx*WORD_W +: WORD_W] <= mem[line_addr][idx];
                    end
                    if (idx == IDX_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed and random line transfers against a line-level memory model.
module tb_mem_line_responder;
    localparam int L  = 4;
    localparam int W  = 4;
    localparam int SL = 1;
    localparam int SW = 1;

    logic         clk;
    logic         rst_b;
    logic         req, req_we;
    logic [7:0]   req_addr;
    logic [127:0] wdata, rdata;
    logic         busy, done;

    logic         s_req, s_we;
    logic [3:0]   s_addr;
    logic [31:0]  s_wdata, s_rdata;
    logic         s_busy, s_done;

    int checks = 0;
    int errors = 0;

    logic [127:0] model_mem [int];
    logic [127:0] exp_rdata;
    logic [31:0]  s_model_mem [int];
    logic [31:0]  s_exp_rdata;
    int           written [$];

    mem_line_responder #(.WORD_W(32), .WORDS(W), .ADDR_W(8), .LATENCY(L)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .req_we(req_we), .req_addr(req_addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done)
    );

    mem_line_responder #(.WORD_W(32), .WORDS(SW), .ADDR_W(4), .LATENCY(SL)) dut_small (
        .clk(clk), .rst_b(rst_b), .req(s_req), .req_we(s_we), .req_addr(s_addr),
        .wdata(s_wdata), .rdata(s_rdata), .busy(s_busy), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Line-level view: the request completes L+W edges after acceptance and
    // the block is idle again one edge later.
    task automatic run_req(input logic we, input logic [7:0] addr, input logic [127:0] data,
                           input bit alter, input logic alt_we, input logic [7:0] alt_addr,
                           input logic [127:0] alt_data, input bit hold);
        @(negedge clk);
        req = 1'b1; req_we = we; req_addr = addr; wdata = data;
        for (int k = 0; k <= L + W + 1; k++) begin
            @(posedge clk); #1;
            check("busy", 128'(busy), 128'(k <= L + W));
            check("done", 128'(done), 128'(k == L + W));
            if (k == L + W) begin
                if (we) model_mem[int'(addr)] = data;
                else    exp_rdata = model_mem[int'(addr)];
                check("rdata", rdata, exp_rdata);
                if (!hold) req = 1'b0;
            end
            if (alter && k == 2) begin
                req_we = alt_we; req_addr = alt_addr; wdata = alt_data;
            end
        end
    endtask

    task automatic run_small(input logic we, input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = data;
        for (int k = 0; k <= SL + SW + 1; k++) begin
            @(posedge clk); #1;
            check("s_busy", 128'(s_busy), 128'(k <= SL + SW));
            check("s_done", 128'(s_done), 128'(k == SL + SW));
            if (k == SL + SW) begin
                if (we) s_model_mem[int'(addr)] = data;
                else    s_exp_rdata = s_model_mem[int'(addr)];
                check("s_rdata", 128'(s_rdata), 128'(s_exp_rdata));
                s_req = 1'b0;
            end
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] old_line, new_line;
        rst_b = 1'b0;
        req = 1'b0; req_we = 1'b0; req_addr = '0; wdata = '0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        exp_rdata = '0; s_exp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_b = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_rdata", rdata, 128'(0));
        check("rst_s_rdata", 128'(s_rdata), 128'(0));

        // writeback then refill of 0x12
        run_req(1'b1, 8'h12, 128'h44444444_33333333_22222222_11111111, 0, 1'b0, 8'h00, '0, 0);
        run_req(1'b0, 8'h12, '0, 0, 1'b0, 8'h00, '0, 0);
        check("wb_rf_line", rdata, 128'h44444444_33333333_22222222_11111111);

        // LATENCY=1, WORDS=1 instance
        run_small(1'b1, 4'h3, 32'hCAFE_0001);
        run_small(1'b0, 4'h3, 32'h0);
        run_small(1'b1, 4'h7, 32'h1234_5678);
        run_small(1'b0, 4'h7, 32'h0);

        // request while busy: 0x34 shows up during 0x12's service and is taken only afterwards
        run_req(1'b1, 8'h34, 128'hABCD_0000_1111_2222_3333_4444_5555_6666, 0, 1'b0, 8'h00, '0, 0);
        run_req(1'b1, 8'h12, 128'h0BAD_F00D_0000_0001_0000_0002_0000_0003, 1, 1'b0, 8'h34, '0, 1);
        run_req(1'b0, 8'h34, '0, 0, 1'b0, 8'h00, '0, 0);
        run_req(1'b0, 8'h12, '0, 0, 1'b0, 8'h00, '0, 0);

        // input hold-off: address and data change after acceptance
        run_req(1'b1, 8'h06, 128'h6666_6666_6666_6666_6666_6666_6666_6666, 0, 1'b0, 8'h00, '0, 0);
        run_req(1'b1, 8'h05, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1, 1'b1, 8'h06,
                128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD, 0);
        run_req(1'b0, 8'h05, '0, 0, 1'b0, 8'h00, '0, 0);
        run_req(1'b0, 8'h06, '0, 0, 1'b0, 8'h00, '0, 0);

        // reset mid-writeback: only the words already transferred change
        old_line = 128'h0404_0404_0303_0303_0202_0202_0101_0101;
        new_line = 128'hD4D4_D4D4_C3C3_C3C3_B2B2_B2B2_A1A1_A1A1;
        run_req(1'b1, 8'h40, old_line, 0, 1'b0, 8'h00, '0, 0);
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 8'h40; wdata = new_line;
        repeat (L + 3) @(posedge clk);
        #1 rst_b = 1'b0; req = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        @(negedge clk); rst_b = 1'b1;
        model_mem[int'(8'h40)] = {old_line[127:64], new_line[63:0]};
        exp_rdata = '0;
        run_req(1'b0, 8'h40, '0, 0, 1'b0, 8'h00, '0, 0);

        // asynchronous reset while done is high
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_addr = 8'h12;
        repeat (L + W + 1) @(posedge clk);
        #1;
        check("pre_rst_done", 128'(done), 128'(1));
        check("pre_rst_rdata", rdata, model_mem[int'(8'h12)]);
        #2 rst_b = 1'b0;
        #1;
        check("async_busy", 128'(busy), 128'(0));
        check("async_done", 128'(done), 128'(0));
        check("async_rdata", rdata, 128'(0));
        req = 1'b0;
        @(negedge clk); rst_b = 1'b1;
        exp_rdata = '0;

        // random traffic
        foreach (model_mem[a]) written.push_back(a);
        for (int n = 0; n < 24; n++) begin
            if (($urandom % 2) == 0) begin
                logic [7:0] a;
                a = 8'($urandom);
                written.push_back(int'(a));
                run_req(1'b1, a, rnd_line(), 0, 1'b0, 8'h00, '0, 0);
            end else begin
                int pick;
                pick = written[$urandom_range(written.size() - 1)];
                run_req(1'b0, 8'(pick), rnd_line(), 0, 1'b0, 8'h00, '0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
